// File: rtl/fifo_param_sync_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fifo_param_sync_if                                          |
// | Brief  : Producer/consumer handshake bundle for fifo_param_sync      |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
interface fifo_param_sync_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_param_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fifo_param_sync                                             |
// | Brief  : Parametrised single-clock FIFO, optional FWFT read mode     |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module fifo_param_sync #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  parameter bit FWFT      = 1'b0
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fifo_param_sync_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;

  assign w_full   = (r_level == LVL_W'(DEPTH));
  assign w_empty  = (r_level == '0);
  // Accept decisions use pre-edge flags only: a same-cycle pop never frees
  // room for a push into a full FIFO, and vice versa.
  assign w_wr_acc = bus.wr_en & ~w_full;
  assign w_rd_acc = bus.rd_en & ~w_empty;

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_level >= LVL_W'(AF_THRESH));
  assign bus.almost_empty = (r_level <= LVL_W'(AE_THRESH));
  assign bus.level        = r_level;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      // A new error in the same cycle as clr_err must stay visible.
      r_overflow  <= (bus.wr_en & w_full)  | (r_overflow  & ~bus.clr_err);
      r_underflow <= (bus.rd_en & w_empty) | (r_underflow & ~bus.clr_err);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.rd_data  = mem[r_rd_ptr];
      assign bus.rd_valid = ~w_empty;
    end else begin : g_std
      logic [DATA_W-1:0] r_rd_data;
      logic              r_rd_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_rd_data <= mem[r_rd_ptr];
        end
      end

      assign bus.rd_data  = r_rd_data;
      assign bus.rd_valid = r_rd_valid;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_fifo_param_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_fifo_param_sync                                          |
// | Brief  : Directed bench, standard and FWFT instances, DEPTH=4        |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_fifo_param_sync;
  logic clk = 1'b0;
  logic rst_s;
  logic rst_f;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fifo_param_sync_if #(.DATA_W(8), .DEPTH(4)) bs ();
  fifo_param_sync_if #(.DATA_W(8), .DEPTH(4)) bf ();

  fifo_param_sync #(.DATA_W(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b0))
    u_std (.clk(clk), .rst(rst_s), .bus(bs));
  fifo_param_sync #(.DATA_W(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b1))
    u_fwft (.clk(clk), .rst(rst_f), .bus(bf));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic std_read(input logic [7:0] exp);
    bs.rd_en = 1'b1;
    tick();
    bs.rd_en = 1'b0;
    check("std_rd_valid", 32'(bs.rd_valid), 32'd1);
    check("std_rd_data", 32'(bs.rd_data), 32'(exp));
  endtask

  logic [7:0] vals [4];
  logic [7:0] wdat;
  logic [7:0] edat;

  initial begin
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    {bs.wr_en, bs.rd_en, bs.clr_err} = 3'b000; bs.wr_data = 8'h00;
    {bf.wr_en, bf.rd_en, bf.clr_err} = 3'b000; bf.wr_data = 8'h00;
    rst_s = 1'b1;
    rst_f = 1'b1;
    tick();
    tick();
    rst_s = 1'b0;
    rst_f = 1'b0;
    tick();

    // Reset / idle state
    check("rst_empty", 32'(bs.empty), 32'd1);
    check("rst_ae", 32'(bs.almost_empty), 32'd1);
    check("rst_level", 32'(bs.level), 32'd0);
    check("rst_full", 32'(bs.full), 32'd0);
    check("rst_af", 32'(bs.almost_full), 32'd0);
    check("rst_rd_valid", 32'(bs.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bs.rd_data), 32'd0);
    check("rst_ovf", 32'(bs.overflow), 32'd0);
    check("rst_unf", 32'(bs.underflow), 32'd0);
    check("rst_fwft_valid", 32'(bf.rd_valid), 32'd0);

    // Fill: level 1..4, almost_full from 3, full at 4
    for (int i = 0; i < 4; i++) begin
      bs.wr_en = 1'b1;
      bs.wr_data = vals[i];
      tick();
      check("fill_level", 32'(bs.level), 32'(i + 1));
      check("fill_af", 32'(bs.almost_full), (i >= 2) ? 32'd1 : 32'd0);
      check("fill_full", 32'(bs.full), (i == 3) ? 32'd1 : 32'd0);
      check("fill_ae", 32'(bs.almost_empty), (i == 0) ? 32'd1 : 32'd0);
    end
    bs.wr_en = 1'b0;

    // Drain with idle gaps: one-cycle rd_valid pulse, rd_data holds
    for (int i = 0; i < 4; i++) begin
      std_read(vals[i]);
      tick();
      check("drain_pulse_end", 32'(bs.rd_valid), 32'd0);
      check("drain_hold", 32'(bs.rd_data), 32'(vals[i]));
    end
    check("drain_empty", 32'(bs.empty), 32'd1);

    // Full + write + read: read wins, write rejected
    for (int i = 0; i < 4; i++) begin
      bs.wr_en = 1'b1;
      bs.wr_data = vals[i];
      tick();
    end
    bs.wr_data = 8'h55;
    bs.rd_en = 1'b1;
    tick();
    bs.wr_en = 1'b0;
    bs.rd_en = 1'b0;
    check("ovf_rd_data", 32'(bs.rd_data), 32'h11);
    check("ovf_flag", 32'(bs.overflow), 32'd1);
    check("ovf_level", 32'(bs.level), 32'd3);
    bs.clr_err = 1'b1;
    tick();
    bs.clr_err = 1'b0;
    check("ovf_cleared", 32'(bs.overflow), 32'd0);
    std_read(8'h22);
    std_read(8'h33);
    std_read(8'h44);
    check("ovf_drain_empty", 32'(bs.empty), 32'd1);

    // Underflow, then set-beats-clear
    bs.rd_en = 1'b1;
    tick();
    check("unf_flag", 32'(bs.underflow), 32'd1);
    check("unf_level", 32'(bs.level), 32'd0);
    check("unf_rd_valid", 32'(bs.rd_valid), 32'd0);
    bs.clr_err = 1'b1;
    tick();
    check("unf_set_wins", 32'(bs.underflow), 32'd1);
    bs.rd_en = 1'b0;
    tick();
    bs.clr_err = 1'b0;
    check("unf_cleared", 32'(bs.underflow), 32'd0);

    // Pointer wrap: 10 rounds of 3 writes / 3 reads
    wdat = 8'h00;
    edat = 8'h00;
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) begin
        bs.wr_en = 1'b1;
        bs.wr_data = wdat;
        wdat++;
        tick();
      end
      bs.wr_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
        std_read(edat);
        edat++;
      end
    end
    check("wrap_empty", 32'(bs.empty), 32'd1);

    // Sustained simultaneous read/write at level 2
    for (int k = 0; k < 2; k++) begin
      bs.wr_en = 1'b1;
      bs.wr_data = wdat;
      wdat++;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      bs.wr_data = wdat;
      wdat++;
      bs.rd_en = 1'b1;
      tick();
      check("stream_level", 32'(bs.level), 32'd2);
      check("stream_data", 32'(bs.rd_data), 32'(edat));
      edat++;
    end
    bs.wr_en = 1'b0;
    bs.rd_en = 1'b0;

    // Reset cancels an in-flight read
    rst_s = 1'b1;
    bs.rd_en = 1'b1;
    tick();
    rst_s = 1'b0;
    bs.rd_en = 1'b0;
    check("midrst_valid", 32'(bs.rd_valid), 32'd0);
    check("midrst_level", 32'(bs.level), 32'd0);
    check("midrst_data", 32'(bs.rd_data), 32'd0);

    // FWFT: word visible one cycle after the write
    bf.wr_en = 1'b1;
    bf.wr_data = 8'hA5;
    tick();
    bf.wr_en = 1'b0;
    check("fwft_valid", 32'(bf.rd_valid), 32'd1);
    check("fwft_data", 32'(bf.rd_data), 32'hA5);
    tick();
    check("fwft_hold", 32'(bf.rd_data), 32'hA5);
    bf.rd_en = 1'b1;
    tick();
    bf.rd_en = 1'b0;
    check("fwft_pop_empty", 32'(bf.empty), 32'd1);
    check("fwft_pop_valid", 32'(bf.rd_valid), 32'd0);
    bf.wr_en = 1'b1;
    bf.wr_data = 8'h01;
    tick();
    bf.wr_data = 8'h02;
    tick();
    bf.wr_en = 1'b0;
    check("fwft_level2", 32'(bf.level), 32'd2);
    check("fwft_head", 32'(bf.rd_data), 32'h01);
    rst_f = 1'b1;
    tick();
    rst_f = 1'b0;
    check("fwft_rst_level", 32'(bf.level), 32'd0);
    check("fwft_rst_valid", 32'(bf.rd_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fifo_param_sync.md
# fifo_param_sync

Parametrised single-clock FIFO, the next generation of the team's fixed 8-bit FIFO tile. Adds configurable data width and depth, programmable almost-full/almost-empty thresholds, a live occupancy count, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. Sits between a byte/word producer (e.g. the `ui_in` capture path) and a consumer (e.g. the `uo_out` drive path) inside a TinyTapeout user project.

## Interface

- `DATA_W`, 8: data word width in bits, ≥1.
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `AF_THRESH`, DEPTH-2: `almost_full` asserts when level ≥ AF_THRESH; range 1..DEPTH.
- `AE_THRESH`, 1: `almost_empty` asserts when level ≤ AE_THRESH; range 0..DEPTH-1.
- `FWFT`, 0: 0 = standard registered read; 1 = first-word-fall-through.
- `LVL_W`, derived $clog2(DEPTH)+1: width of `level`. Not overridable.

Ports:

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write request.
- `wr_data` in DATA_W: write word.
- `rd_en` in 1: read request (pop in FWFT mode).
- `rd_data` out DATA_W: read word.
- `rd_valid` out 1: `rd_data` holds a valid word.
- `full` out 1: level == DEPTH.
- `empty` out 1: level == 0.
- `almost_full` out 1: level ≥ AF_THRESH.
- `almost_empty` out 1: level ≤ AE_THRESH.
- `level` out LVL_W: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a write was attempted while full.
- `underflow` out 1: sticky; a read was attempted while empty.
- `clr_err` in 1: clears `overflow` and `underflow`.

## Operation

- Storage: DEPTH×DATA_W register array, not reset. Write and read pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. `level` is a separate registered counter.
- Write accept = `wr_en & ~full`. Read accept = `rd_en & ~empty`. `full` and `empty` are evaluated on the pre-edge state. A read in the same cycle does not unblock a write to a full FIFO, and a write in the same cycle does not unblock a read from an empty FIFO.
- Level update: +1 on write-only accept, −1 on read-only accept, unchanged when both are accepted or neither is. Level never exceeds DEPTH and never goes below 0.
- Flags `full`, `empty`, `almost_full`, `almost_empty` are decoded combinationally from the registered `level`. They carry no extra latency beyond `level`.
- Standard mode (FWFT=0):
  - `rd_data` is registered and loads mem[rd_ptr] on read accept.
  - `rd_valid` pulses high for exactly the cycle after each accepted read.
  - `rd_data` holds its last value otherwise.
- FWFT mode (FWFT=1):
  - `rd_data` = mem[rd_ptr] (combinational from registered state).
  - `rd_valid` = ~empty.
  - `rd_en` acknowledges/pops the displayed word.
- Error flags:
  - `overflow` sets on `wr_en & full`; `underflow` sets on `rd_en & empty`.
  - Both hold until `clr_err`. Set wins over clear in the same cycle.
  - Rejected operations change no pointer, level, or data.
- Reset clears pointers, level and error flags.
  - Outputs after reset: `empty`=1, `full`=0, `level`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0, `rd_valid`=0.
  - `rd_data`=0 in standard mode; don't-care in FWFT mode while empty.
- Reset mid-operation discards all stored data, and any in-flight `rd_valid` pulse is cancelled.

## Timing

- Write at edge N: `level`, `empty` and the flags reflect it after edge N.
- Write-to-first-read latency:
  - Standard mode: `rd_en` is accepted at edge N+1, and data with `rd_valid` appear after edge N+1. That is 2 cycles from the write edge to data out.
  - FWFT mode: word visible with `rd_valid`=1 after edge N, i.e. 1 cycle.
- Sustained throughput: one write and one read per cycle. With the FIFO neither empty nor full, simultaneous read and write hold `level` constant indefinitely.
- `rst` is sampled only on a rising `clk` edge and takes priority over all other inputs.

## Test plan

All scenarios use DEPTH=4, DATA_W=8, AF_THRESH=3, AE_THRESH=1 unless stated.

- Reset then idle → `empty`=1, `almost_empty`=1, `level`=0, `full`=0, `rd_valid`=0, `overflow`=0, `underflow`=0.
- Write 0x11, 0x22, 0x33, 0x44 (FWFT=0) → `level` 1,2,3,4; `almost_full` rises at level 3; `full`=1 at 4. Then 4 reads → `rd_data` 0x11..0x44 in order, each with a one-cycle `rd_valid` pulse; `empty`=1 at end.
- With FIFO full, a 5th write of 0x55 together with `rd_en` → read returns 0x11, write rejected, `overflow`=1, `level`=3. Then `clr_err` → `overflow`=0.
- Read while empty → `underflow`=1, `level` stays 0, `rd_valid`=0. Same-cycle `rd_en` plus `clr_err` while empty → `underflow` stays 1.
- Pointer wrap: 10 rounds of 3 writes then 3 reads with incrementing data 0x00.. → output sequence strictly increments with no loss or duplication.
- FWFT=1: write 0xA5 → next cycle `rd_valid`=1 and `rd_data`=0xA5 with no `rd_en`. Pulse `rd_en` → `empty`=1. Assert `rst` with 2 entries stored → `level`=0 and `rd_valid`=0 after the edge.
